// File: rtl/dma_pkg.sv
// ----------------------------------------------------------------------------
// dma_pkg
//   Shared definitions for the burst DMA address/sequencing engine:
//   the controller state encoding and the bytes-per-beat helper used to
//   advance source and destination addresses.
// ----------------------------------------------------------------------------
package dma_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

    // Address step for one beat of the given width.
    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/dma_burst_controller.sv
// ----------------------------------------------------------------------------
// dma_burst_controller
//   Single-channel memory-to-memory burst DMA sequencer. An accepted start
//   latches the source/destination addresses and beat count, then for each
//   beat issues one read strobe at the source address followed by one write
//   strobe at the destination address. Both addresses advance by one beat
//   (DATA_WIDTH/8 bytes) after each write. All outputs are registered.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   start          : start request, honoured only in IDLE or DONE
//   src_addr       : first source byte address
//   dst_addr       : first destination byte address
//   burst_len      : number of beats (0 completes immediately)
//   done           : transfer complete, held until the next accepted start
//   curr_src_addr  : source address of current beat / final address
//   curr_dst_addr  : destination address of current beat / final address
//   curr_burst_len : beats remaining
//   read_en        : read strobe for curr_src_addr
//   write_en       : write strobe for curr_dst_addr
//   align_err      : (DMA_ALIGN_CHECK_EN only) start rejected, unaligned address
//
// Configuration
//   DMA_ALIGN_CHECK_EN : when defined, unaligned start addresses complete the
//                        transfer at once with align_err set and no strobes.
// ----------------------------------------------------------------------------
module dma_burst_controller
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [BURST_LEN-1:0]  burst_len,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] curr_src_addr,
    output logic [ADDR_WIDTH-1:0] curr_dst_addr,
    output logic [BURST_LEN-1:0]  curr_burst_len,
    output logic                  read_en,
    output logic                  write_en
`ifdef DMA_ALIGN_CHECK_EN
    ,
    output logic                  align_err
`endif
);

    localparam int unsigned BPB = beat_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPB);

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [BURST_LEN-1:0]  len_q, len_d;
    logic                  done_q, done_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;

`ifdef DMA_ALIGN_CHECK_EN
    logic align_q, align_d;
    logic misaligned;

    assign misaligned = ((src_addr % ADDR_STEP) != '0) || ((dst_addr % ADDR_STEP) != '0);
`endif

    // State and output registers; reset clears everything so strobes drop
    // the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef DMA_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            done_q  <= done_d;
            read_q  <= read_d;
            write_q <= write_d;
`ifdef DMA_ALIGN_CHECK_EN
            align_q <= align_d;
`endif
        end
    end

    // Next-state logic. Strobes are computed for the state being entered so
    // that the registered read_en/write_en line up with READ/WRITE exactly.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        done_d  = done_q;
        read_d  = 1'b0;
        write_d = 1'b0;
`ifdef DMA_ALIGN_CHECK_EN
        align_d = align_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = burst_len;
                    done_d = 1'b0;
`ifdef DMA_ALIGN_CHECK_EN
                    align_d = 1'b0;
                    if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        align_d = 1'b1;
                    end else
`endif
                    if (burst_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        read_d  = 1'b1;
                    end
                end
            end

            READ: begin
                state_d = WRITE;
                write_d = 1'b1;
            end

            WRITE: begin
                src_d = src_q + ADDR_STEP;
                dst_d = dst_q + ADDR_STEP;
                len_d = len_q - BURST_LEN'(1);
                // The beat just written was the last one when one remained.
                if (len_q == BURST_LEN'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                    read_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done           = done_q;
    assign curr_src_addr  = src_q;
    assign curr_dst_addr  = dst_q;
    assign curr_burst_len = len_q;
    assign read_en        = read_q;
    assign write_en       = write_q;
`ifdef DMA_ALIGN_CHECK_EN
    assign align_err      = align_q;
`endif

endmodule

// File: tb/tb_dma_burst_controller.sv
// ----------------------------------------------------------------------------
// tb_dma_burst_controller
//   Directed bench for dma_burst_controller with a timeline model: each
//   accepted start is recorded with its edge number, and every cycle the
//   expected outputs are derived from how many edges have passed since.
// ----------------------------------------------------------------------------
module tb_dma_burst_controller;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BL  = 4;
   localparam int BPB = DW / 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [BL-1:0] burst_len;
   logic          done;
   logic [AW-1:0] curr_src_addr;
   logic [AW-1:0] curr_dst_addr;
   logic [BL-1:0] curr_burst_len;
   logic          read_en;
   logic          write_en;
`ifdef DMA_ALIGN_CHECK_EN
   logic          align_err;
`endif

   int total = 0;
   int bad   = 0;

   dma_burst_controller #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .BURST_LEN (BL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .burst_len     (burst_len),
      .done          (done),
      .curr_src_addr (curr_src_addr),
      .curr_dst_addr (curr_dst_addr),
      .curr_burst_len(curr_burst_len),
      .read_en       (read_en),
      .write_en      (write_en)
`ifdef DMA_ALIGN_CHECK_EN
      ,
      .align_err     (align_err)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point shared by the model checker and literal checks.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: the last accepted start and the edge it was accepted on.
   int            cyc    = 0;
   int            t0     = 0;
   bit            active = 0;
   bit            mErr   = 0;
   int            mN     = 0;
   logic [AW-1:0] mSrc   = '0;
   logic [AW-1:0] mDst   = '0;

   // Track accepted starts; a transfer is busy for 2N edges after acceptance.
   initial begin
      bit busy;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            active = 0;
         end else if (start) begin
            busy = active && !mErr && ((cyc - 1 - t0) < 2 * mN);
            if (!busy) begin
               t0     = cyc;
               active = 1;
               mSrc   = src_addr;
               mDst   = dst_addr;
               mN     = int'(burst_len);
`ifdef DMA_ALIGN_CHECK_EN
               mErr   = ((src_addr % BPB) != 0) || ((dst_addr % BPB) != 0);
`else
               mErr   = 0;
`endif
            end
         end
      end
   end

   // Every falling edge: derive expected outputs from elapsed edges.
   initial begin
      int            d;
      int            beat;
      logic          eDone, eRd, eWr, eAl;
      logic [AW-1:0] eSrc, eDst;
      int            eLen;
      forever begin
         @(negedge clk);
         eDone = 0; eRd = 0; eWr = 0; eAl = 0;
         eSrc = '0; eDst = '0; eLen = 0;
         if (active) begin
            d = cyc - t0;
            if (mErr) begin
               eDone = 1; eAl = 1;
               eSrc = mSrc; eDst = mDst; eLen = mN;
            end else if (d < 2 * mN) begin
               beat = d / 2;
               eRd  = (d % 2) == 0;
               eWr  = (d % 2) == 1;
               eSrc = mSrc + AW'(beat * BPB);
               eDst = mDst + AW'(beat * BPB);
               eLen = mN - beat;
            end else begin
               eDone = 1;
               eSrc = mSrc + AW'(mN * BPB);
               eDst = mDst + AW'(mN * BPB);
               eLen = 0;
            end
         end
         checkOutput("done",     done,           eDone);
         checkOutput("read_en",  read_en,        eRd);
         checkOutput("write_en", write_en,       eWr);
         checkOutput("curr_src", curr_src_addr,  eSrc);
         checkOutput("curr_dst", curr_dst_addr,  eDst);
         checkOutput("curr_len", curr_burst_len, 64'(eLen));
`ifdef DMA_ALIGN_CHECK_EN
         checkOutput("align_err", align_err,     eAl);
`endif
      end
   end

   // Strobe log used by the literal address-sequence checks.
   logic [AW-1:0] rdQ[$];
   logic [AW-1:0] wrQ[$];
   initial begin
      forever begin
         @(negedge clk);
         if (read_en)  rdQ.push_back(curr_src_addr);
         if (write_en) wrQ.push_back(curr_dst_addr);
      end
   end

   // One-cycle start pulse; returns at the falling edge after acceptance.
   task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] dd, input int n);
      @(negedge clk);
      src_addr  = s;
      dst_addr  = dd;
      burst_len = BL'(n);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Falling edges until done is seen; an expired budget counts as a failure.
   task automatic waitDone(input int budget, output int lat);
      lat = 0;
      while (!done && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (!done) checkOutput("done_timeout", 64'(lat), 64'(budget + 1));
   endtask

   int lat;

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      burst_len = '0;

      // Reset held for 100 ns
      #95;
      checkOutput("rst_done",  done,           1'b0);
      checkOutput("rst_rd",    read_en,        1'b0);
      checkOutput("rst_wr",    write_en,       1'b0);
      checkOutput("rst_src",   curr_src_addr,  '0);
      checkOutput("rst_dst",   curr_dst_addr,  '0);
      checkOutput("rst_len",   curr_burst_len, '0);
      #5 rst_n = 1'b1;

      // Basic four-beat transfer
      rdQ.delete(); wrQ.delete();
      applyStimulus(32'h0000_0000, 32'h1000_0000, 4);
      waitDone(50, lat);
      checkOutput("t1_latency", 64'(lat), 64'd8);
      checkOutput("t1_nrd", 64'(rdQ.size()), 64'd4);
      checkOutput("t1_nwr", 64'(wrQ.size()), 64'd4);
      if (rdQ.size() == 4 && wrQ.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput("t1_rd_addr", rdQ[i], 32'(i * 4));
            checkOutput("t1_wr_addr", wrQ[i], 32'h1000_0000 + 32'(i * 4));
         end
      end
      checkOutput("t1_src", curr_src_addr,  32'h0000_0010);
      checkOutput("t1_dst", curr_dst_addr,  32'h1000_0010);
      checkOutput("t1_len", curr_burst_len, 4'd0);

      // Zero-length transfer
      rdQ.delete(); wrQ.delete();
      applyStimulus(32'h0000_0100, 32'h0000_0200, 0);
      waitDone(10, lat);
      checkOutput("t2_latency", 64'(lat), 64'd0);
      repeat (2) @(negedge clk);
      checkOutput("t2_strobes", 64'(rdQ.size() + wrQ.size()), 64'd0);
      checkOutput("t2_src", curr_src_addr, 32'h0000_0100);
      checkOutput("t2_dst", curr_dst_addr, 32'h0000_0200);

      // Address wrap
      applyStimulus(32'hFFFF_FFF8, 32'h0000_2000, 4);
      waitDone(50, lat);
      checkOutput("t3_src", curr_src_addr, 32'h0000_0008);
      checkOutput("t3_dst", curr_dst_addr, 32'h0000_2010);

      // Start during a transfer is ignored
      applyStimulus(32'h0000_0040, 32'h0000_0080, 3);
      @(negedge clk);
      src_addr  = 32'h0000_0900;
      dst_addr  = 32'h0000_0A00;
      burst_len = 4'd7;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      waitDone(50, lat);
      checkOutput("t4_src", curr_src_addr, 32'h0000_004C);
      checkOutput("t4_dst", curr_dst_addr, 32'h0000_008C);

      // Reset mid-transfer aborts, then a fresh start works
      applyStimulus(32'h0000_0000, 32'h0000_0000, 5);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_abort_rd",   read_en,  1'b0);
      checkOutput("t5_abort_wr",   write_en, 1'b0);
      checkOutput("t5_abort_done", done,     1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h0000_0300, 32'h0000_0400, 2);
      waitDone(50, lat);
      checkOutput("t5_latency", 64'(lat), 64'd4);
      checkOutput("t5_src", curr_src_addr, 32'h0000_0308);

`ifdef DMA_ALIGN_CHECK_EN
      // Unaligned source rejected, aligned restart clears the error
      rdQ.delete(); wrQ.delete();
      applyStimulus(32'h0000_0002, 32'h0000_1000, 3);
      waitDone(10, lat);
      checkOutput("t6_latency", 64'(lat), 64'd0);
      checkOutput("t6_align",   align_err, 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("t6_strobes", 64'(rdQ.size() + wrQ.size()), 64'd0);
      checkOutput("t6_src", curr_src_addr,  32'h0000_0002);
      checkOutput("t6_len", curr_burst_len, 4'd3);
      applyStimulus(32'h0000_0010, 32'h0000_0020, 1);
      checkOutput("t6_clear", align_err, 1'b0);
      waitDone(20, lat);
      checkOutput("t6_src2", curr_src_addr, 32'h0000_0014);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case something never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
